poly_bank_io: RTL and testbench
===============================

// Module: poly_bank_io
// PURPOSE
// Polynomial I/O buffer between the serial host stream and the PE-parallel NTT/INTT cores.
// Holds NUM_POLY coefficient slots, each banked into LANES = 2^(PE_DEPTH+1) words per row.
// Writes a serial stream into a slot, optionally bit-reversing the coefficient index.
// Streams a slot back out one full row per cycle, and gives the core row-wide random access while idle.
// PARAMETERS
// DATA_W      64  coefficient width in bits (matches DATA_SIZE_ARB)
// RING_DEPTH  10  log2 of ring size, N = 2^RING_DEPTH
// PE_DEPTH    3   log2 of PE count, LANES = 2^(PE_DEPTH+1), ROWS = N/LANES
// NUM_POLY    2   number of polynomial slots; PSEL_W = max(1, clog2(NUM_POLY))
// PORTS
// clk        in   1               single clock, all logic on rising edge
// reset      in   1               synchronous, active-high
// load_data  in   1               1-cycle pulse: start a serial load
// unload     in   1               1-cycle pulse: start a row-wide stream out
// poly_sel   in   PSEL_W          target slot, sampled with load_data/unload
// bitrev_en  in   1               sampled with load_data: 1 = store coeff k at bitrev(k)
// din        in   DATA_W          serial coefficient
// din_valid  in   1               din qualifier during LOAD
// dout       out  DATA_W*LANES    row data, lane n at [DATA_W*n +: DATA_W]
// dout_valid out  1               dout qualifier
// dout_last  out  1               high with the final row of an unload
// load_done  out  1               1-cycle pulse after the N-th accepted word
// busy       out  1               high in LOAD or UNLOAD
// core_we    in   1               core row write, honoured only when busy = 0
// core_psel  in   PSEL_W          core slot select
// core_addr  in   RING_DEPTH-PE_DEPTH-1  core row address
// core_wdata in   DATA_W*LANES    core row write data
// core_rdata out  DATA_W*LANES    core row read data, 1-cycle latency, always reads core_psel/core_addr
// BEHAVIOUR
// - Reset: FSM to IDLE; counters cleared; dout, dout_valid, dout_last, load_done, busy, core_rdata = 0.
// - Reset does not clear the memory contents.
// - FSM states: IDLE, LOAD, UNLOAD.
// - IDLE -> LOAD on load_data. load_data has priority when load_data and unload are high in the same cycle.
// - IDLE -> UNLOAD on unload. Pulses arriving while busy are ignored.
// - Slot and bitrev_en are latched on entry to LOAD/UNLOAD and held for the whole operation.
// - LOAD: busy = 1 from the cycle after load_data.
//   - Each cycle with din_valid = 1 accepts din as coefficient k (k = 0..N-1).
//   - Address idx = bitrev_en ? bitrev_RING_DEPTH(k) : k; row = idx >> (PE_DEPTH+1), lane = idx[PE_DEPTH:0].
//   - Only that lane of that row is written.
//   - Cycles with din_valid = 0 stall without advancing k.
//   - When k = N-1 is accepted: next cycle load_done = 1, busy = 0, state IDLE.
// - UNLOAD: reads rows 0..ROWS-1 on consecutive cycles, one read per cycle, no stalls.
//   - RAM latency is 1: row r appears on dout with dout_valid = 1 exactly 2 cycles after the unload pulse + r.
//   - dout_last = 1 with row ROWS-1.
//   - busy falls together with the last dout_valid cycle.
//   - dout holds its last value after the stream ends; dout_valid = 0.
// - Core port:
//   - core_we while busy is dropped; no error is flagged.
//   - Reads through core_rdata are always permitted.
//   - A write followed by a read of the same row on the next cycle returns the new data.
// - Reset mid-LOAD or mid-UNLOAD: the operation aborts and the FSM is IDLE next cycle.
//   - Rows already written are kept; no load_done or dout_last is issued.
// - Storage: LANES banks, each NUM_POLY*ROWS deep, single write port per bank. Inferred as BRAM.
// TESTING (defaults: N=1024, LANES=16, ROWS=64)
// 1 Natural load: din = k for k = 0..1023, din_valid = 1, slot 0, then unload.
//   -> load_done exactly 1 cycle after word 1023; 64 dout_valid cycles; row m lane n = 16m+n; dout_last on row 63.
// 2 Bit-reversed load: bitrev_en = 1, din = k, then unload.
//   -> word k = 1 appears at row 32, lane 0; word 2 at row 16, lane 0; word 1023 at row 63, lane 15.
// 3 Gapped stream: din_valid low every 3rd cycle, data as in test 1.
//   -> identical unload data to test 1; load_done only after 1024 accepted words.
// 4 Two slots: load slot 0 with k and slot 1 with k+5000, then unload slot 1 and then slot 0.
//   -> slot 1 rows give 16m+n+5000; slot 0 rows give 16m+n; no cross-slot corruption.
// 5 Reset after 500 words of a load.
//   -> busy = 0 the next cycle; no load_done; a fresh full load afterwards completes correctly.
// 6 Contention:
//   -> load_data and unload in the same cycle: LOAD is entered.
//   -> core_we row 5 during LOAD: ignored, row 5 unchanged.
//   -> core_we row 5 = 0xA5 pattern while IDLE: read back on core_rdata 1 cycle later.

Source files
------------

// File: rtl/poly_bank_io.sv
// Polynomial I/O buffer: serial (optionally bit-reversed) load into a slot, row-wide stream out,
// and row-wide core access while idle. Storage is LANES banks, one coefficient lane each.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for load_data/unload; core port may write
// S_LOAD   | accepting serial coefficients until N words are taken
// S_UNLOAD | reading rows 0..ROWS-1, one row per cycle
module poly_bank_io #(
    parameter int DATA_W     = 64,
    parameter int RING_DEPTH = 10,
    parameter int PE_DEPTH   = 3,
    parameter int NUM_POLY   = 2,
    localparam int LANES     = 2 ** (PE_DEPTH + 1),
    localparam int PSEL_W    = (NUM_POLY > 1) ? $clog2(NUM_POLY) : 1,
    localparam int ROW_W     = RING_DEPTH - PE_DEPTH - 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_data,
    input  logic                    unload,
    input  logic [PSEL_W-1:0]       poly_sel,
    input  logic                    bitrev_en,
    input  logic [DATA_W-1:0]       din,
    input  logic                    din_valid,
    output logic [DATA_W*LANES-1:0] dout,
    output logic                    dout_valid,
    output logic                    dout_last,
    output logic                    load_done,
    output logic                    busy,
    input  logic                    core_we,
    input  logic [PSEL_W-1:0]       core_psel,
    input  logic [ROW_W-1:0]        core_addr,
    input  logic [DATA_W*LANES-1:0] core_wdata,
    output logic [DATA_W*LANES-1:0] core_rdata
);
    localparam int N      = 2 ** RING_DEPTH;
    localparam int ROWS   = N / LANES;
    localparam int DEPTH  = NUM_POLY * ROWS;
    localparam int AW     = $clog2(DEPTH);
    localparam int LANE_W = PE_DEPTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UNLOAD} state_t;

    state_t                  state, state_nx;
    logic [RING_DEPTH-1:0]   k_cnt;
    logic [ROW_W-1:0]        row_cnt;
    logic [PSEL_W-1:0]       psel_q;
    logic                    bitrev_q;
    logic [RING_DEPTH-1:0]   coef_idx;
    logic                    load_wr, last_word, last_row, core_wr;
    logic [AW-1:0]           wr_addr, ur_addr, cr_addr;

    function automatic logic [RING_DEPTH-1:0] bit_reverse(input logic [RING_DEPTH-1:0] v);
        logic [RING_DEPTH-1:0] r;
        for (int i = 0; i < RING_DEPTH; i++) r[i] = v[RING_DEPTH-1-i];
        return r;
    endfunction

    // Slot-major layout inside every bank: slot p occupies rows [p*ROWS, (p+1)*ROWS).
    function automatic logic [AW-1:0] slot_addr(input logic [PSEL_W-1:0] p,
                                                input logic [ROW_W-1:0] r);
        return AW'(int'(p) * ROWS + int'(r));
    endfunction

    assign coef_idx  = bitrev_q ? bit_reverse(k_cnt) : k_cnt;
    assign load_wr   = (state == S_LOAD) && din_valid;
    assign last_word = load_wr && (k_cnt == RING_DEPTH'(N - 1));
    assign last_row  = (state == S_UNLOAD) && (row_cnt == ROW_W'(ROWS - 1));
    assign core_wr   = (state == S_IDLE) && core_we;
    assign wr_addr   = load_wr ? slot_addr(psel_q, coef_idx[RING_DEPTH-1:LANE_W])
                               : slot_addr(core_psel, core_addr);
    assign ur_addr   = slot_addr(psel_q, row_cnt);
    assign cr_addr   = slot_addr(core_psel, core_addr);
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (load_data)   state_nx = S_LOAD;
                else if (unload) state_nx = S_UNLOAD;
            end
            S_LOAD:   if (last_word) state_nx = S_IDLE;
            S_UNLOAD: if (last_row)  state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            k_cnt      <= '0;
            row_cnt    <= '0;
            psel_q     <= '0;
            bitrev_q   <= 1'b0;
            load_done  <= 1'b0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            state      <= state_nx;
            load_done  <= last_word;
            dout_valid <= (state == S_UNLOAD);
            dout_last  <= last_row;
            if (state == S_IDLE && (load_data || unload)) begin
                psel_q   <= poly_sel;
                bitrev_q <= bitrev_en;
                k_cnt    <= '0;
                row_cnt  <= '0;
            end
            if (load_wr)            k_cnt   <= k_cnt + 1'b1;
            if (state == S_UNLOAD)  row_cnt <= row_cnt + 1'b1;
        end
    end

    for (genvar b = 0; b < LANES; b++) begin : g_bank
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] wdata, dout_lane, rdata_lane;
        logic              bank_we;

        assign bank_we = !reset && (core_wr || (load_wr && coef_idx[LANE_W-1:0] == LANE_W'(b)));
        assign wdata   = load_wr ? din : core_wdata[b*DATA_W +: DATA_W];

        always_ff @(posedge clk) begin
            if (bank_we) mem[wr_addr] <= wdata;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                dout_lane  <= '0;
                rdata_lane <= '0;
            end else begin
                rdata_lane <= mem[cr_addr];
                if (state == S_UNLOAD) dout_lane <= mem[ur_addr];
            end
        end

        assign dout[b*DATA_W +: DATA_W]       = dout_lane;
        assign core_rdata[b*DATA_W +: DATA_W] = rdata_lane;
    end

endmodule

// File: tb/tb_poly_bank_io.sv
// Randomized scoreboard bench for poly_bank_io: a coefficient-array model predicts every
// unloaded row; a negedge monitor pops and compares whenever dout_valid is high.
module tb_poly_bank_io;
    localparam int DATA_W     = 64;
    localparam int RING_DEPTH = 10;
    localparam int PE_DEPTH   = 3;
    localparam int NUM_POLY   = 2;
    localparam int LANES      = 16;
    localparam int N          = 1024;
    localparam int ROWS       = 64;
    localparam int ROW_BITS   = DATA_W * LANES;

    typedef logic [ROW_BITS-1:0] row_t;

    logic clk = 1'b0;
    logic reset, load_data, unload, bitrev_en, din_valid, core_we;
    logic [0:0] poly_sel, core_psel;
    logic [DATA_W-1:0] din;
    logic [5:0] core_addr;
    row_t core_wdata, dout, core_rdata;
    logic dout_valid, dout_last, load_done, busy;

    poly_bank_io #(.DATA_W(DATA_W), .RING_DEPTH(RING_DEPTH), .PE_DEPTH(PE_DEPTH),
                   .NUM_POLY(NUM_POLY)) dut (
        .clk(clk), .reset(reset), .load_data(load_data), .unload(unload),
        .poly_sel(poly_sel), .bitrev_en(bitrev_en), .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
        .load_done(load_done), .busy(busy), .core_we(core_we), .core_psel(core_psel),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata)
    );

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_pass  = 0;
    logic [DATA_W-1:0] model_mem [NUM_POLY][N];
    logic [DATA_W-1:0] stim [N];
    row_t exp_rows [$];
    bit   exp_last [$];
    row_t last_row_seen;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else n_pass++;
    endtask

    task automatic chk_row(input string name, input row_t got, input row_t exp);
        n_total++;
        if (got !== exp) begin
            for (int n = 0; n < LANES; n++)
                if (got[n*DATA_W +: DATA_W] !== exp[n*DATA_W +: DATA_W]) begin
                    $display("FAIL %s lane %0d: got %h expected %h", name, n,
                             got[n*DATA_W +: DATA_W], exp[n*DATA_W +: DATA_W]);
                    break;
                end
        end else n_pass++;
    endtask

    function automatic int brev(input int k);
        int r = 0;
        for (int i = 0; i < RING_DEPTH; i++) r = r | (((k >> i) & 1) << (RING_DEPTH - 1 - i));
        return r;
    endfunction

    function automatic row_t model_row(input int slot, input int r);
        row_t v;
        for (int n = 0; n < LANES; n++) v[n*DATA_W +: DATA_W] = model_mem[slot][r*LANES + n];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid output row must match the oldest predicted row.
    initial begin
        forever begin
            @(negedge clk);
            if (dout_valid) begin
                if (exp_rows.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_row: got dout_valid=1 expected no row pending");
                end else begin
                    row_t e;
                    bit   l;
                    e = exp_rows.pop_front();
                    l = exp_last.pop_front();
                    chk_row("unload_row", dout, e);
                    chk("dout_last", 64'(dout_last), 64'(l));
                    chk("busy_during_stream", 64'(busy), 64'(!l));
                    last_row_seen = e;
                end
            end
        end
    end

    // gap: 0 = continuous, 1 = din_valid low every 3rd cycle, 2 = random gaps
    task automatic do_load(input int slot, input bit br, input int gap, input bit both,
                           input bit poke, input int abort_at);
        int k = 0;
        int c = 0;
        bit early = 0;
        bit v;
        load_data = 1; unload = both; poly_sel = 1'(slot); bitrev_en = br;
        tick();
        load_data = 0; unload = 0;
        chk("busy_on_load", 64'(busy), 64'd1);
        while (k < N) begin
            v = (gap == 0) ? 1'b1 : (gap == 1) ? (c % 3 != 2) : ($urandom_range(0, 3) != 0);
            din_valid = v;
            din = stim[k];
            if (poke) begin
                core_we = 1; core_psel = 1'(slot); core_addr = 6'd5;
                core_wdata = {LANES{64'hDEAD_BEEF_0BAD_F00D}};
            end
            if (v) begin
                model_mem[slot][br ? brev(k) : k] = stim[k];
                k++;
            end
            c++;
            tick();
            if (k < N && load_done) early = 1;
            if (abort_at > 0 && k == abort_at) begin
                din_valid = 0; core_we = 0; reset = 1;
                tick();
                reset = 0;
                chk("busy_after_abort", 64'(busy), 64'd0);
                chk("no_done_after_abort", 64'(load_done), 64'd0);
                tick();
                chk("no_done_later", 64'(load_done), 64'd0);
                return;
            end
        end
        din_valid = 0; core_we = 0;
        chk("load_done_pulse", 64'(load_done), 64'd1);
        chk("busy_after_load", 64'(busy), 64'd0);
        chk("load_done_not_early", 64'(early), 64'd0);
        tick();
        chk("load_done_one_cycle", 64'(load_done), 64'd0);
    endtask

    task automatic do_unload(input int slot);
        for (int r = 0; r < ROWS; r++) begin
            exp_rows.push_back(model_row(slot, r));
            exp_last.push_back(r == ROWS - 1);
        end
        unload = 1; poly_sel = 1'(slot);
        tick();
        unload = 0;
        chk("no_valid_before_latency", 64'(dout_valid), 64'd0);
        tick();
        chk("first_row_latency", 64'(dout_valid), 64'd1);
        repeat (ROWS) tick();
        chk("valid_low_after_stream", 64'(dout_valid), 64'd0);
        chk("rows_all_seen", 64'(exp_rows.size()), 64'd0);
        chk_row("dout_holds", dout, last_row_seen);
        exp_rows.delete();
        exp_last.delete();
    endtask

    task automatic core_read(input int slot, input int r, output row_t got);
        core_psel = 1'(slot); core_addr = 6'(r);
        tick();
        got = core_rdata;
    endtask

    initial begin
        row_t rd;
        reset = 1; load_data = 0; unload = 0; poly_sel = 0; bitrev_en = 0; din = '0;
        din_valid = 0; core_we = 0; core_psel = 0; core_addr = '0; core_wdata = '0;
        repeat (3) tick();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_dout_valid", 64'(dout_valid), 64'd0);
        chk("reset_dout_last", 64'(dout_last), 64'd0);
        chk("reset_load_done", 64'(load_done), 64'd0);
        chk_row("reset_dout", dout, '0);
        chk_row("reset_core_rdata", core_rdata, '0);
        reset = 0;
        tick();

        for (int k = 0; k < N; k++) stim[k] = 64'(k);
        do_load(0, 0, 0, 0, 0, 0);
        do_unload(0);
        core_read(0, 3, rd);
        chk_row("core_read_row3", rd, model_row(0, 3));

        do_load(0, 1, 0, 0, 0, 0);
        do_unload(0);
        core_read(0, 32, rd);
        chk("brev_k1_row32_lane0", rd[63:0], 64'd1);
        core_read(0, 16, rd);
        chk("brev_k2_row16_lane0", rd[63:0], 64'd2);
        core_read(0, 63, rd);
        chk("brev_k1023_row63_lane15", rd[15*DATA_W +: DATA_W], 64'd1023);

        do_load(0, 0, 1, 0, 0, 0);
        do_unload(0);

        do_load(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < N; k++) stim[k] = 64'(k + 5000);
        do_load(1, 0, 0, 0, 0, 0);
        do_unload(1);
        do_unload(0);

        for (int k = 0; k < N; k++) stim[k] = {$urandom, $urandom};
        do_load(1, 1, 0, 0, 0, 500);
        do_unload(1);
        for (int k = 0; k < N; k++) stim[k] = 64'(k + 7);
        do_load(1, 0, 0, 0, 0, 0);
        do_unload(1);

        for (int k = 0; k < N; k++) stim[k] = 64'(k);
        do_load(0, 0, 0, 1, 1, 0);
        do_unload(0);
        core_we = 1; core_psel = 0; core_addr = 6'd5;
        core_wdata = {(ROW_BITS/8){8'hA5}};
        tick();
        core_we = 0;
        for (int n = 0; n < LANES; n++) model_mem[0][5*LANES + n] = {8{8'hA5}};
        tick();
        chk_row("core_write_readback", core_rdata, {(ROW_BITS/8){8'hA5}});
        do_unload(0);

        for (int it = 0; it < 3; it++) begin
            int s;
            bit b;
            s = $urandom_range(0, NUM_POLY - 1);
            b = 1'($urandom_range(0, 1));
            for (int k = 0; k < N; k++) stim[k] = {$urandom, $urandom};
            do_load(s, b, 2, 0, 0, 0);
            do_unload(s);
            do_unload(1 - s);
        end

        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
